// File: rtl/instr_fetch_unit_if.sv
// Fetch-side bundle: instruction memory read port, decode handshake and redirect.
interface instr_fetch_unit_if;
    logic [31:0] A_IM;
    logic [31:0] RD_IM;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        misalign_err;

    modport master (
        output A_IM,
        input  RD_IM,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        input  redirect,
        input  redirect_pc,
        output misalign_err
    );

    modport slave (
        input  A_IM,
        output RD_IM,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        output redirect,
        output redirect_pc,
        input  misalign_err
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch unit: owns the PC, issues one-deep memory reads and buffers
// {pc, instr} pairs in a prefetch FIFO for decode.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] PC_STEP    = 32'd4
) (
    input  logic                CLK,
    input  logic                RST,
    instr_fetch_unit_if.master  bus
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        FLUSH,
        ERR
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    state_t         state, state_n;
    logic [31:0]    pc, pc_n;
    logic [31:0]    req_pc, req_pc_n;
    logic           inflight, inflight_n;
    logic           discard, discard_n;
    logic [PW-1:0]  wptr, wptr_n;
    logic [PW-1:0]  rptr, rptr_n;
    logic [CW-1:0]  count, count_n;
    entry_t         fifo [FIFO_DEPTH];

    logic           redir;
    logic           credit_ok;
    logic           issue;
    logic           push;
    logic           pop;
    entry_t         head;

    assign head             = fifo[rptr];
    assign bus.A_IM         = pc;
    assign bus.out_valid    = (count != '0);
    assign bus.out_instr    = bus.out_valid ? head.instr : 32'h0;
    assign bus.out_pc       = bus.out_valid ? head.pc : 32'h0;
    assign bus.misalign_err = (state == ERR);

    // Credit check counts the in-flight word so a response always has a slot.
    assign redir     = bus.redirect && (state != BOOT);
    assign credit_ok = (count + CW'(inflight)) < CW'(FIFO_DEPTH);
    assign issue     = (state == RUN) && !redir && credit_ok;
    assign push      = inflight && !discard && !redir;
    assign pop       = bus.out_valid && bus.out_ready;

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        req_pc_n   = req_pc;
        inflight_n = issue;
        discard_n  = 1'b0;
        wptr_n     = wptr;
        rptr_n     = rptr;
        count_n    = count;

        if (push) wptr_n = wptr + PW'(1);
        if (pop)  rptr_n = rptr + PW'(1);

        unique case (1'b1)
            push && !pop: count_n = count + CW'(1);
            pop && !push: count_n = count - CW'(1);
            default:      count_n = count;
        endcase

        if (issue) begin
            req_pc_n = pc;
            pc_n     = pc + PC_STEP;
        end

        unique case (state)
            BOOT:  state_n = RUN;
            RUN:   state_n = RUN;
            FLUSH: state_n = RUN;
            ERR:   state_n = ERR;
        endcase

        // Redirect clears the queue; an old head popped this cycle is still taken.
        if (redir) begin
            discard_n = inflight;
            pc_n      = bus.redirect_pc;
            wptr_n    = '0;
            rptr_n    = '0;
            count_n   = '0;
            state_n   = (bus.redirect_pc[1:0] == 2'b00) ? FLUSH : ERR;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= BOOT;
            pc       <= RESET_PC;
            req_pc   <= RESET_PC;
            inflight <= 1'b0;
            discard  <= 1'b0;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            req_pc   <= req_pc_n;
            inflight <= inflight_n;
            discard  <= discard_n;
            wptr     <= wptr_n;
            rptr     <= rptr_n;
            count    <= count_n;
        end
    end

    always_ff @(posedge CLK) begin
        if (push && !RST) begin
            fifo[wptr] <= '{pc: req_pc, instr: bus.RD_IM};
        end
    end

endmodule
